// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and limits for the LSU data-port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    ACK
  } arb_state_e;

  localparam int MAX_RD_LAT = 4;

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way round-robin pick with a pointer that remembers which master is favoured next.
module rr_arb2 (
  input  logic i_clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  input  logic upd_en,
  input  logic upd_ptr,
  output logic gnt
);

  logic ptr;

  // The pointer only breaks ties; a lone requester always wins.
  always_comb begin
    gnt = 1'b0;
    if (req0 && req1) begin
      gnt = ptr;
    end else if (req1) begin
      gnt = 1'b1;
    end
  end

  // Pointer resets to favour m0 and moves only when a transaction completes.
  always_ff @(posedge i_clk) begin
    if (!rst) begin
      ptr <= 1'b0;
    end else if (upd_en) begin
      ptr <= upd_ptr;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single LSU data port between the core (m0) and the debug/loader port (m1).
// One transaction in flight at a time, sequenced as issue -> read wait -> ack.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              i_clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              lsu_we,
  output logic              lsu_re,
  output logic [ADDR_W-1:0] lsu_addr,
  output logic [DATA_W-1:0] lsu_wdata,
  input  logic [DATA_W-1:0] lsu_rdata,
  output logic              o_busy,
  output logic              o_gnt_id
);

  localparam int CNT_W = $clog2(RD_LAT) + 1;

  arb_state_e        state_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              gnt_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              pick;
  logic              issuing;
  logic              acking;

  rr_arb2 u_rr_arb2 (
    .i_clk   (i_clk),
    .rst     (rst),
    .req0    (m0_req),
    .req1    (m1_req),
    .upd_en  (acking),
    .upd_ptr (~gnt_q),
    .gnt     (pick)
  );

  // Transaction sequencer: latches the winner's payload once, so later payload changes are ignored.
  always_ff @(posedge i_clk) begin
    if (!rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      gnt_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (m0_req || m1_req) begin
            gnt_q   <= pick;
            we_q    <= pick ? m1_we : m0_we;
            addr_q  <= pick ? m1_addr : m0_addr;
            wdata_q <= pick ? m1_wdata : m0_wdata;
            rdata_q <= '0;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (we_q) begin
            state_q <= ACK;
          end else begin
            cnt_q   <= CNT_W'(RD_LAT - 1);
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            rdata_q <= lsu_rdata;
            state_q <= ACK;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ACK: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Outputs are pure decodes of the state and the latched transaction.
  always_comb begin
    issuing   = (state_q == ISSUE);
    acking    = (state_q == ACK);
    lsu_we    = issuing && we_q;
    lsu_re    = issuing && !we_q;
    lsu_addr  = issuing ? addr_q : '0;
    lsu_wdata = (issuing && we_q) ? wdata_q : '0;
    m0_ack    = acking && !gnt_q;
    m1_ack    = acking && gnt_q;
    m0_rdata  = m0_ack ? rdata_q : '0;
    m1_rdata  = m1_ack ? rdata_q : '0;
    o_busy    = (state_q != IDLE);
    o_gnt_id  = gnt_q;
  end

endmodule
